// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register bank.
//   state_e : handshake FSM state encoding
//   clog2   : register-index width for a given register count
package gpr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Ceiling log2, floored at 1 so a register index is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gpr_bank_if.sv
// Access bus of the register bank.
//   master : drives cs, req, we, waddr, wdata, raddr_a, raddr_b
//   slave  : drives rdata_a, rdata_b, rdy, ack, err
interface gpr_bank_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  cs;
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr_a;
  logic [ADDR_WIDTH-1:0] raddr_b;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  rdy;
  logic                  ack;
  logic                  err;

  modport master (
    output cs, req, we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, rdy, ack, err
  );

  modport slave (
    input  cs, req, we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, rdy, ack, err
  );
endinterface

// File: rtl/gpr_bank_array.sv
// Register storage: one synchronous write port, two combinational read ports.
//   clk, rst            : clock, async active-high reset (clears all registers)
//   we, waddr, wdata    : write port (index already range-checked by the caller)
//   raddr_a/b           : read indices
//   rdata_a_c/rdata_b_c : combinational read data, R0 masked when ZERO_R0=1
module gpr_bank_array #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ZERO_R0    = 0,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr_a,
  input  logic [IDX_W-1:0]      raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a_c,
  output logic [DATA_WIDTH-1:0] rdata_b_c
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic zero_r0;
  assign zero_r0 = (ZERO_R0 != 0);

  // Write port; writes to a hardwired R0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (we && !(zero_r0 && (waddr == '0))) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports with R0 masking.
  assign rdata_a_c = (zero_r0 && (raddr_a == '0)) ? '0 : regs[raddr_a];
  assign rdata_b_c = (zero_r0 && (raddr_b == '0)) ? '0 : regs[raddr_b];

endmodule

// File: rtl/gpr_bank.sv
// General-purpose register bank with cs/req -> rdy/ack handshake.
//   clk, rst : clock, async active-high reset
//   bus      : gpr_bank_if slave (request in, read data / rdy / ack / err out)
// One write and two reads per access; write-first bypass; out-of-range
// addresses suppress the write, read as 0 and raise err alongside ack.
module gpr_bank
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ZERO_R0    = 0
) (
  input  logic       clk,
  input  logic       rst,
  gpr_bank_if.slave  bus
);

  localparam int unsigned IDX_W = clog2(NUM_REGS);

  state_e                state;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] raddr_a_q;
  logic [ADDR_WIDTH-1:0] raddr_b_q;
  logic [DATA_WIDTH-1:0] rdata_a_q;
  logic [DATA_WIDTH-1:0] rdata_b_q;
  logic                  rdy_q;
  logic                  ack_q;
  logic                  err_q;

  logic                  wr_oor_c;
  logic                  ra_oor_c;
  logic                  rb_oor_c;
  logic                  wr_take_c;
  logic                  wr_en_c;
  logic                  err_c;
  logic [DATA_WIDTH-1:0] arr_a_c;
  logic [DATA_WIDTH-1:0] arr_b_c;
  logic [DATA_WIDTH-1:0] rd_a_c;
  logic [DATA_WIDTH-1:0] rd_b_c;

  // Out of range when any bit above the register index is set.
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> IDX_W) != '0;
  endfunction

  // Range checks, write qualification and bypass on the captured request.
  always_comb begin
    wr_oor_c  = out_of_range(waddr_q);
    ra_oor_c  = out_of_range(raddr_a_q);
    rb_oor_c  = out_of_range(raddr_b_q);
    wr_take_c = we_q && !wr_oor_c &&
                !((ZERO_R0 != 0) && (waddr_q[IDX_W-1:0] == '0));
    wr_en_c   = (state == ST_ACCESS) && wr_take_c;
    err_c     = ra_oor_c || rb_oor_c || (we_q && wr_oor_c);

    rd_a_c = arr_a_c;
    if (ra_oor_c) begin
      rd_a_c = '0;
    end else if (wr_take_c && (raddr_a_q == waddr_q)) begin
      rd_a_c = wdata_q;
    end

    rd_b_c = arr_b_c;
    if (rb_oor_c) begin
      rd_b_c = '0;
    end else if (wr_take_c && (raddr_b_q == waddr_q)) begin
      rd_b_c = wdata_q;
    end
  end

  gpr_bank_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ZERO_R0    (ZERO_R0),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .we        (wr_en_c),
    .waddr     (waddr_q[IDX_W-1:0]),
    .wdata     (wdata_q),
    .raddr_a   (raddr_a_q[IDX_W-1:0]),
    .raddr_b   (raddr_b_q[IDX_W-1:0]),
    .rdata_a_c (arr_a_c),
    .rdata_b_c (arr_b_c)
  );

  // Handshake FSM with request capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      rdy_q     <= 1'b1;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cs && bus.req) begin
            we_q      <= bus.we;
            waddr_q   <= bus.waddr;
            wdata_q   <= bus.wdata;
            raddr_a_q <= bus.raddr_a;
            raddr_b_q <= bus.raddr_b;
            rdy_q     <= 1'b0;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rdata_a_q <= rd_a_c;
          rdata_b_q <= rd_b_c;
          err_q     <= err_c;
          ack_q     <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          rdy_q <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          rdy_q <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;
  assign bus.rdy     = rdy_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_gpr_bank.sv
// Bench for gpr_bank: two instances (ZERO_R0=0 and 1) share one stimulus bus.
module tb_gpr_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpr_bank_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus0 ();
  gpr_bank_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus1 ();

  assign bus1.cs      = bus0.cs;
  assign bus1.req     = bus0.req;
  assign bus1.we      = bus0.we;
  assign bus1.waddr   = bus0.waddr;
  assign bus1.wdata   = bus0.wdata;
  assign bus1.raddr_a = bus0.raddr_a;
  assign bus1.raddr_b = bus0.raddr_b;

  gpr_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_REGS(8), .ZERO_R0(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gpr_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_REGS(8), .ZERO_R0(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a0, b0, a1, b1;
    logic        err0, err1;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] wa, wd, ra, rb;
    logic [15:0] xa, xb;
    logic        xerr;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] m0 [8];
  logic [15:0] m1 [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic oor(input logic [15:0] a);
    logic [12:0] hi;
    hi = a[15:3];
    return hi != 13'd0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      m0[i] = 16'h0;
      m1[i] = 16'h0;
    end
  endtask

  // Reference behaviour for both instances; updates the model memories.
  task automatic model(input logic we, input logic [15:0] wa, wd, ra, rb, output exp_t e);
    logic w0, w1;
    w0 = we && !oor(wa);
    w1 = w0 && (wa[2:0] != 3'd0);
    e.a0 = oor(ra) ? 16'h0 : (w0 && ra == wa) ? wd : m0[ra[2:0]];
    e.b0 = oor(rb) ? 16'h0 : (w0 && rb == wa) ? wd : m0[rb[2:0]];
    e.a1 = (oor(ra) || ra[2:0] == 3'd0) ? 16'h0 : (w1 && ra == wa) ? wd : m1[ra[2:0]];
    e.b1 = (oor(rb) || rb[2:0] == 3'd0) ? 16'h0 : (w1 && rb == wa) ? wd : m1[rb[2:0]];
    e.err0 = oor(ra) || oor(rb) || (we && oor(wa));
    e.err1 = e.err0;
    if (w0) m0[wa[2:0]] = wd;
    if (w1) m1[wa[2:0]] = wd;
  endtask

  // One handshake access; expectations are queued at drive, popped at ack.
  task automatic run_access(input logic we, input logic [15:0] wa, wd, ra, rb,
                            input logic use_tab, input logic [15:0] xa, xb,
                            input logic xerr);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!bus0.rdy && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.rdy) check("rdy_timeout", 32'd0, 32'd1);
    bus0.cs = 1'b1; bus0.req = 1'b1; bus0.we = we;
    bus0.waddr = wa; bus0.wdata = wd; bus0.raddr_a = ra; bus0.raddr_b = rb;
    model(we, wa, wd, ra, rb, e);
    if (use_tab) begin
      e.a0 = xa; e.b0 = xb; e.err0 = xerr;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; they must not matter any more.
    bus0.req = 1'b0; bus0.cs = 1'($urandom); bus0.we = 1'($urandom);
    bus0.waddr = 16'($urandom); bus0.wdata = 16'($urandom);
    bus0.raddr_a = 16'($urandom); bus0.raddr_b = 16'($urandom);
    @(negedge clk);
    check("access_rdy", 32'(bus0.rdy), 32'd0);
    check("access_ack", 32'(bus0.ack), 32'd0);
    n = 0;
    while (!bus0.ack && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.ack) begin
      check("ack_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check("rdata_a0", 32'(bus0.rdata_a), 32'(e.a0));
      check("rdata_b0", 32'(bus0.rdata_b), 32'(e.b0));
      check("err0",     32'(bus0.err),     32'(e.err0));
      check("ack1",     32'(bus1.ack),     32'd1);
      check("rdata_a1", 32'(bus1.rdata_a), 32'(e.a1));
      check("rdata_b1", 32'(bus1.rdata_b), 32'(e.b1));
      check("err1",     32'(bus1.err),     32'(e.err1));
      @(negedge clk);
      check("ack_pulse", 32'(bus0.ack), 32'd0);
      check("rdy_back",  32'(bus0.rdy), 32'd1);
      check("hold_a0",   32'(bus0.rdata_a), 32'(e.a0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    vec_t tab [12];
    int   acks;

    tab[0]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1'b0};
    tab[1]  = '{1'b0, 16'h0000, 16'h0000, 16'h0006, 16'h0007, 16'h0000, 16'h0000, 1'b0};
    tab[2]  = '{1'b1, 16'h0003, 16'hBEEF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1'b0};
    tab[3]  = '{1'b0, 16'h0000, 16'h0000, 16'h0003, 16'h0002, 16'hBEEF, 16'h0000, 1'b0};
    tab[4]  = '{1'b1, 16'h0005, 16'h1234, 16'h0005, 16'h0003, 16'h1234, 16'hBEEF, 1'b0};
    tab[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h0005, 16'h0004, 16'h1234, 16'h0000, 1'b0};
    tab[6]  = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0005, 16'hFFFF, 16'h1234, 1'b0};
    tab[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'hFFFF, 16'hBEEF, 1'b0};
    tab[8]  = '{1'b1, 16'h0009, 16'hAAAA, 16'h0001, 16'h0003, 16'h0000, 16'hBEEF, 1'b1};
    tab[9]  = '{1'b0, 16'h0000, 16'h0000, 16'h0008, 16'h0001, 16'h0000, 16'h0000, 1'b1};
    tab[10] = '{1'b0, 16'h0009, 16'h5555, 16'h0002, 16'h0003, 16'h0000, 16'hBEEF, 1'b0};
    tab[11] = '{1'b0, 16'h0000, 16'h0000, 16'h8003, 16'h0003, 16'h0000, 16'hBEEF, 1'b1};

    rst = 1'b1;
    bus0.cs = 1'b0; bus0.req = 1'b0; bus0.we = 1'b0;
    bus0.waddr = '0; bus0.wdata = '0; bus0.raddr_a = '0; bus0.raddr_b = '0;
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_rdy",     32'(bus0.rdy),     32'd1);
    check("rst_ack",     32'(bus0.ack),     32'd0);
    check("rst_err",     32'(bus0.err),     32'd0);
    check("rst_rdata_a", 32'(bus0.rdata_a), 32'd0);
    check("rst_rdata_b", 32'(bus0.rdata_b), 32'd0);
    check("rst_rdy1",    32'(bus1.rdy),     32'd1);
    rst = 1'b0;

    // req without cs must be ignored.
    bus0.req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("nocs_rdy", 32'(bus0.rdy), 32'd1);
      check("nocs_ack", 32'(bus0.ack), 32'd0);
    end
    bus0.req = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_access(1'b0, 16'h0, 16'h0, 16'(i), 16'(7 - i), 1'b1, 16'h0, 16'h0, 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      run_access(tab[i].we, tab[i].wa, tab[i].wd, tab[i].ra, tab[i].rb,
                 1'b1, tab[i].xa, tab[i].xb, tab[i].xerr);
    end

    // req held high: back-to-back accesses, one every three cycles.
    @(negedge clk);
    bus0.cs = 1'b1; bus0.req = 1'b1; bus0.we = 1'b0;
    bus0.raddr_a = 16'h0003; bus0.raddr_b = 16'h0005;
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (bus0.ack) acks++;
    end
    bus0.req = 1'b0;
    check("b2b_acks", 32'(acks), 32'd3);
    repeat (3) @(negedge clk);
    check("b2b_rdata_a", 32'(bus0.rdata_a), 32'h0000BEEF);
    check("b2b_rdata_b", 32'(bus0.rdata_b), 32'h00001234);

    // Reset during ACCESS aborts the access and clears the bank.
    @(negedge clk);
    bus0.cs = 1'b1; bus0.req = 1'b1; bus0.we = 1'b1;
    bus0.waddr = 16'h0006; bus0.wdata = 16'h5555;
    bus0.raddr_a = 16'h0006; bus0.raddr_b = 16'h0000;
    @(posedge clk);
    #1;
    bus0.req = 1'b0;
    @(negedge clk);
    check("mid_rdy_pre", 32'(bus0.rdy), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rdy",     32'(bus0.rdy),     32'd1);
    check("mid_ack",     32'(bus0.ack),     32'd0);
    check("mid_rdata_a", 32'(bus0.rdata_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    run_access(1'b0, 16'h0, 16'h0, 16'h0006, 16'h0003, 1'b1, 16'h0, 16'h0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run_access(1'($urandom), 16'($urandom_range(0, 9)), 16'($urandom),
                 16'($urandom_range(0, 9)), 16'($urandom_range(0, 9)),
                 1'b0, 16'h0, 16'h0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
